// File: rtl/fir_pkg.sv
// Shared FIR sample-domain definitions.
//   SAMPLE_W / ACC_W   : sample and accumulator widths
//   SAT_MAX / SAT_MIN  : clamp limits of the sample domain
//   rq_t               : result of a requantize step (saturation hit + value)
//   round_shift_sat()  : round-half-up right shift followed by saturation
package fir_pkg;

  localparam int SAMPLE_W = 12;
  localparam int ACC_W    = 32;

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef struct packed {
    logic                       sat;
    logic signed [SAMPLE_W-1:0] value;
  } rq_t;

  // One guard bit above ACC_W keeps the rounding add from overflowing at the
  // positive extreme. The arithmetic shift floors, so adding half an LSB
  // first gives round-half-up.
  function automatic rq_t round_shift_sat(input logic signed [ACC_W-1:0] din,
                                          input int unsigned             shift);
    logic signed [ACC_W:0] t, r, rnd, hi, lo;
    rq_t res;
    hi  = (ACC_W+1)'(SAT_MAX);
    lo  = (ACC_W+1)'(SAT_MIN);
    rnd = '0;
    if (shift != 0) rnd = (ACC_W+1)'(1) << (shift - 1);
    t = {din[ACC_W-1], din} + rnd;
    r = t >>> shift;
    res.sat   = 1'b0;
    res.value = r[SAMPLE_W-1:0];
    if (r > hi) begin
      res.sat   = 1'b1;
      res.value = SAT_MAX;
    end else if (r < lo) begin
      res.sat   = 1'b1;
      res.value = SAT_MIN;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
//   clk, reset        : clock, async active-high reset
//   wr_en, wr_data    : write request (ignored when full unless read same cycle)
//   rd_en, rd_data    : pop request; rd_data shows the head, 0 when empty
//   full, empty, level: status; level is the occupancy 0..DEPTH
module sync_fifo_fwft #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

  assign do_rd = rd_en && !empty;
  // When full, a same-cycle pop frees the slot being overwritten; the head is
  // read combinationally before the edge so the old value is not lost.
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fir_out_requant.sv
// Requantizes the wide FIR output stream back to the sample domain.
//   clk, reset   : clock, async active-high reset
//   in_valid/in_y: FIR output stream, no backpressure
//   clr_flags    : synchronous clear of sticky flags (a same-cycle set wins)
//   out_valid/out_ready/out_x : FWFT output port, out_x is 0 when empty
//   sat_flag     : sticky, a kept sample saturated
//   drop_flag    : sticky, a kept sample was lost because the FIFO was full
//   fifo_level   : output FIFO occupancy
// IN_W must not exceed ACC_W and OUT_W must equal SAMPLE_W (shared helper).
module fir_out_requant
  import fir_pkg::*;
#(
  parameter int IN_W       = ACC_W,
  parameter int OUT_W      = SAMPLE_W,
  parameter int SHIFT      = 8,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic signed [IN_W-1:0]        in_y,
  input  logic                          clr_flags,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_x,
  output logic                          sat_flag,
  output logic                          drop_flag,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int CW     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int STAGES = 1;

  logic [CW-1:0]         cnt;
  logic                  keep;
  rq_t                   rq;
  logic [STAGES:0]       vld_pipe;
  logic [OUT_W-1:0]      s1_data;
  logic                  full, empty, rd, drop;
  logic [OUT_W-1:0]      head;

  // Decimation: keep the sample seen while the counter sits at 0.
  assign keep = in_valid && (cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (in_valid)
      cnt <= (cnt == CW'(DECIM-1)) ? '0 : cnt + 1'b1;
  end

  assign rq          = round_shift_sat(ACC_W'(in_y), SHIFT);
  assign vld_pipe[0] = keep;

  // Stage 1: registered requantized sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe[STAGES:1] <= '0;
      s1_data            <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (keep) s1_data <= rq.value;
    end
  end

  assign out_valid = !empty;
  assign rd        = out_valid && out_ready;
  assign drop      = vld_pipe[STAGES] && full && !rd;

  sync_fifo_fwft #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (vld_pipe[STAGES]),
    .wr_data (s1_data),
    .rd_en   (rd),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign out_x = head;

  // Sticky flags: set has priority over clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag  <= 1'b0;
      drop_flag <= 1'b0;
    end else begin
      if (keep && rq.sat) sat_flag <= 1'b1;
      else if (clr_flags) sat_flag <= 1'b0;
      if (drop)           drop_flag <= 1'b1;
      else if (clr_flags) drop_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_out_requant.sv
module tb_fir_out_requant;
  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [31:0] in_y;
  logic               clr_flags;
  logic               out_ready;

  logic               out_valid1, sat1, drop1;
  logic signed [11:0] out_x1;
  logic [2:0]         level1;

  logic               out_valid2, sat2, drop2;
  logic signed [11:0] out_x2;
  logic [2:0]         level2;

  int ntests = 0;
  int nfail  = 0;
  int pops2  = 0;
  int cnt2   = 0;

  logic signed [11:0] q1[$];
  logic signed [11:0] q2[$];

  always #5 clk = ~clk;

  fir_out_requant #(.SHIFT(8), .DECIM(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_y(in_y),
    .clr_flags(clr_flags), .out_valid(out_valid1), .out_ready(out_ready),
    .out_x(out_x1), .sat_flag(sat1), .drop_flag(drop1), .fifo_level(level1));

  // Decimating instance sees the same stream and is never stalled.
  fir_out_requant #(.SHIFT(8), .DECIM(3), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_y(in_y),
    .clr_flags(clr_flags), .out_valid(out_valid2), .out_ready(1'b1),
    .out_x(out_x2), .sat_flag(sat2), .drop_flag(drop2), .fifo_level(level2));

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: floor((y + 128) / 256) in 64-bit math, then clamp.
  function automatic logic signed [11:0] mdl(input logic signed [31:0] y);
    longint v;
    v = (longint'(y) + 64'sd128) >>> 8;
    if (v > 2047) v = 2047;
    else if (v < -2048) v = -2048;
    return v[11:0];
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one sample for one cycle. exp1 says whether dut1 is expected to
  // deliver it (the bench decides drops); dut2 uses its own decimation model.
  task automatic send(input logic signed [31:0] y, input bit exp1);
    in_valid = 1'b1;
    in_y     = y;
    if (exp1) q1.push_back(mdl(y));
    if (cnt2 == 0) q2.push_back(mdl(y));
    cnt2 = (cnt2 + 1) % 3;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q1.delete();
    q2.delete();
    cnt2 = 0;
    step(2);
    reset = 1'b0;
  endtask

  // Scoreboard monitors: a transfer at the coming edge pops one expectation.
  always @(negedge clk) begin
    if (!reset && out_valid1 && out_ready) begin
      if (q1.size() == 0) chk("dut1_unexpected_out", out_x1, 32'sd9999);
      else chk("dut1_out_x", out_x1, q1.pop_front());
    end
    if (!reset && out_valid2) begin
      pops2++;
      if (q2.size() == 0) chk("dut2_unexpected_out", out_x2, 32'sd9999);
      else chk("dut2_out_x", out_x2, q2.pop_front());
    end
  end

  initial begin
    in_valid  = 1'b0;
    in_y      = '0;
    clr_flags = 1'b0;
    out_ready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out_x",     out_x1,     0);
    chk("rst_level",     level1,     0);
    chk("rst_sat",       sat1,       0);
    chk("rst_drop",      drop1,      0);

    // 1) rounding
    send(384, 1);
    send(-384, 1);
    send(128, 1);
    send(127, 1);
    step(3);
    chk("t1_sat_clear", sat1, 0);
    chk("t1_q_empty", q1.size(), 0);

    // 2) saturation and flag clear
    send(32'sh7FFFFFFF, 1);
    chk("t2_sat_set", sat1, 1);
    send(32'sh80000000, 1);
    step(3);
    chk("t2_q_empty", q1.size(), 0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t2_sat_cleared", sat1, 0);

    // 3) fill with stall, two drops, then drain
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send(256 * k, k <= 4);
    step(2);
    chk("t3_level", level1, 4);
    chk("t3_drop", drop1, 1);
    chk("t3_head", out_x1, 1);
    out_ready = 1'b1;
    step(4);
    chk("t3_drained_valid", out_valid1, 0);
    chk("t3_drained_x", out_x1, 0);
    chk("t3_q_empty", q1.size(), 0);

    // 4) write into a full FIFO with a same-cycle read
    out_ready = 1'b0;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("t4_drop_cleared", drop1, 0);
    for (int k = 1; k <= 4; k++) send(256 * k, 1);
    step();
    chk("t4_full_level", level1, 4);
    send(1280, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_level_stays", level1, 4);
    chk("t4_no_drop", drop1, 0);
    out_ready = 1'b1;
    step(5);
    chk("t4_drained", out_valid1, 0);
    chk("t4_no_drop_end", drop1, 0);
    chk("t4_q_empty", q1.size(), 0);

    // 5) decimation by 3 on dut2
    do_reset();
    pops2 = 0;
    for (int k = 1; k <= 9; k++) send(256 * k, 1);
    step(4);
    chk("t5_dut2_count", pops2, 3);
    chk("t5_q2_empty", q2.size(), 0);
    chk("t5_q1_empty", q1.size(), 0);

    // 6) asynchronous reset mid-stream
    out_ready = 1'b0;
    send(256, 1);
    send(512, 1);
    send(768, 1);
    step();
    chk("t6_level3", level1, 3);
    send(32'sh7FFFFFFF, 0);
    chk("t6_sat_before", sat1, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid1, 0);
    chk("t6_rst_level", level1, 0);
    chk("t6_rst_x", out_x1, 0);
    chk("t6_rst_sat", sat1, 0);
    chk("t6_rst_drop", drop1, 0);
    q1.delete();
    q2.delete();
    cnt2 = 0;
    #2 reset = 1'b0;
    step();
    out_ready = 1'b1;
    send(256 * 9, 1);
    step(3);
    chk("t6_first_kept_q1", q1.size(), 0);
    chk("t6_first_kept_q2", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
